// File: rtl/dcache_store_port.sv
// Purpose : store-buffer-to-memory write port; turns a byte-addressed store into an aligned write with lane data and byte strobes.
// Latency : accept in N, mem_req_valid_o from N+1, response earliest N+2, next accept earliest N+3 (one store per 3 cycles).
// Backpr. : one store outstanding; sb_req_ready_o is high only in IDLE, and the request is held stable until mem_req_ready_i.
//
// Ports:
//   clk_i, rst_ni                   clock, async active-low reset
//   sb_req_valid/ready/addr/data/op  store-buffer head handshake
//   mem_req_valid/ready/addr/wdata/wstrb  memory write request
//   mem_rsp_valid_i, mem_rsp_err_i   write response
//   store_err_o/_cause_o/_addr_o     one-cycle error report (0 bus, 1 timeout, 2 misaligned, 3 illegal op)
//   idle_o                           nothing held or in flight
//
// Build option: define DCACHE_STORE_PORT_MISALIGN_CHECK_EN to reject misaligned
// SH/SW/SD with cause 2. Without it, sub-word lanes are rounded down to natural alignment.

package config_pkg;
    typedef struct packed {
        int unsigned PLEN;
        int unsigned XLEN;
    } cfg_t;

    localparam cfg_t DefaultCfg = '{PLEN: 32, XLEN: 32};
endpackage

package decode_pkg;
    typedef enum logic [3:0] {
        LSU_LB, LSU_LH, LSU_LW, LSU_LD,
        LSU_SB, LSU_SH, LSU_SW, LSU_SD
    } lsu_op_e;
endpackage

module dcache_store_port #(
    parameter config_pkg::cfg_t Cfg            = config_pkg::DefaultCfg,
    parameter int unsigned      TIMEOUT_CYCLES = 256
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,

    input  logic                        sb_req_valid_i,
    output logic                        sb_req_ready_o,
    input  logic [Cfg.PLEN-1:0]         sb_req_addr_i,
    input  logic [Cfg.XLEN-1:0]         sb_req_data_i,
    input  decode_pkg::lsu_op_e         sb_req_op_i,

    output logic                        mem_req_valid_o,
    input  logic                        mem_req_ready_i,
    output logic [Cfg.PLEN-1:0]         mem_req_addr_o,
    output logic [Cfg.XLEN-1:0]         mem_req_wdata_o,
    output logic [Cfg.XLEN/8-1:0]       mem_req_wstrb_o,
    input  logic                        mem_rsp_valid_i,
    input  logic                        mem_rsp_err_i,

    output logic                        store_err_o,
    output logic [1:0]                  store_err_cause_o,
    output logic [Cfg.PLEN-1:0]         store_err_addr_o,
    output logic                        idle_o
);
    import decode_pkg::*;

    localparam int unsigned PLEN  = Cfg.PLEN;
    localparam int unsigned XLEN  = Cfg.XLEN;
    localparam int unsigned BYTES = XLEN / 8;
    localparam int unsigned OFF_W = $clog2(BYTES);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

`ifdef DCACHE_STORE_PORT_MISALIGN_CHECK_EN
    localparam bit MISALIGN_EN = 1'b1;
`else
    localparam bit MISALIGN_EN = 1'b0;
`endif

    localparam logic [1:0] CAUSE_BUS      = 2'd0;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'd1;
    localparam logic [1:0] CAUSE_MISALIGN = 2'd2;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'd3;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

    state_e             state_q;
    logic [PLEN-1:0]    addr_q;
    logic [PLEN-1:0]    orig_addr_q;
    logic [XLEN-1:0]    wdata_q;
    logic [BYTES-1:0]   wstrb_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               err_q;
    logic [1:0]         err_cause_q;

    // Lane decode of the incoming store
    logic [OFF_W-1:0]   off;
    logic [OFF_W-1:0]   lane_off;
    logic [BYTES-1:0]   wstrb_d;
    logic [XLEN-1:0]    wdata_d;
    logic [PLEN-1:0]    addr_d;
    logic               legal_op;
    logic               misaligned;

    always_comb begin
        off        = sb_req_addr_i[OFF_W-1:0];
        lane_off   = off;
        wstrb_d    = '0;
        legal_op   = 1'b0;
        misaligned = 1'b0;
        case (sb_req_op_i)
            LSU_SB: begin
                legal_op = 1'b1;
                wstrb_d  = BYTES'(1) << off;
            end
            LSU_SH: begin
                legal_op   = 1'b1;
                misaligned = off[0];
                lane_off   = off & ~OFF_W'(1);
                wstrb_d    = BYTES'(3) << lane_off;
            end
            LSU_SW: begin
                legal_op   = 1'b1;
                misaligned = (off[1:0] != 2'b00);
                lane_off   = off & ~OFF_W'(3);
                wstrb_d    = BYTES'(4'hF) << lane_off;
            end
            LSU_SD: begin
                // Only a legal op on a 64-bit datapath; always a full-width write.
                legal_op   = (XLEN == 64);
                misaligned = (off != '0);
                lane_off   = '0;
                wstrb_d    = '1;
            end
            default: ;
        endcase
        wdata_d = sb_req_data_i << {lane_off, 3'b000};
        addr_d  = {sb_req_addr_i[PLEN-1:OFF_W], OFF_W'(0)};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            orig_addr_q <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            err_cause_q <= 2'd0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sb_req_valid_i) begin
                        addr_q      <= addr_d;
                        wdata_q     <= wdata_d;
                        wstrb_q     <= wstrb_d;
                        orig_addr_q <= sb_req_addr_i;
                        if (!legal_op) begin
                            err_q       <= 1'b1;
                            err_cause_q <= CAUSE_ILLEGAL;
                        end else if (MISALIGN_EN && misaligned) begin
                            err_q       <= 1'b1;
                            err_cause_q <= CAUSE_MISALIGN;
                        end else begin
                            state_q <= REQ;
                        end
                    end
                end
                REQ: begin
                    // A response in this cycle is not ours yet and is ignored.
                    if (mem_req_ready_i) begin
                        state_q <= WAIT;
                        cnt_q   <= '0;
                    end
                end
                WAIT: begin
                    if (mem_rsp_valid_i) begin
                        state_q <= IDLE;
                        if (mem_rsp_err_i) begin
                            err_q       <= 1'b1;
                            err_cause_q <= CAUSE_BUS;
                        end
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state_q     <= IDLE;
                        err_q       <= 1'b1;
                        err_cause_q <= CAUSE_TIMEOUT;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sb_req_ready_o    = (state_q == IDLE);
    assign idle_o            = (state_q == IDLE);
    assign mem_req_valid_o   = (state_q == REQ);
    assign mem_req_addr_o    = addr_q;
    assign mem_req_wdata_o   = wdata_q;
    assign mem_req_wstrb_o   = wstrb_q;
    assign store_err_o       = err_q;
    assign store_err_cause_o = err_cause_q;
    assign store_err_addr_o  = orig_addr_q;

endmodule

// File: tb/tb_dcache_store_port.sv
// Purpose : directed bench for dcache_store_port (XLEN=32, PLEN=32, TIMEOUT_CYCLES=8).
// Timing  : inputs driven and outputs sampled 1 time unit after each rising edge.
// Flow    : memory ready is driven per scenario; responses are driven by hand.

module tb_dcache_store_port;
    import decode_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sb_req_valid;
    logic        sb_req_ready;
    logic [31:0] sb_req_addr;
    logic [31:0] sb_req_data;
    lsu_op_e     sb_req_op;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_rsp_valid;
    logic        mem_rsp_err;
    logic        store_err;
    logic [1:0]  store_err_cause;
    logic [31:0] store_err_addr;
    logic        idle;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    dcache_store_port #(.TIMEOUT_CYCLES(8)) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .sb_req_valid_i    (sb_req_valid),
        .sb_req_ready_o    (sb_req_ready),
        .sb_req_addr_i     (sb_req_addr),
        .sb_req_data_i     (sb_req_data),
        .sb_req_op_i       (sb_req_op),
        .mem_req_valid_o   (mem_req_valid),
        .mem_req_ready_i   (mem_req_ready),
        .mem_req_addr_o    (mem_req_addr),
        .mem_req_wdata_o   (mem_req_wdata),
        .mem_req_wstrb_o   (mem_req_wstrb),
        .mem_rsp_valid_i   (mem_rsp_valid),
        .mem_rsp_err_i     (mem_rsp_err),
        .store_err_o       (store_err),
        .store_err_cause_o (store_err_cause),
        .store_err_addr_o  (store_err_addr),
        .idle_o            (idle)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one store for a single cycle; it is accepted at that edge when the port is idle.
    task automatic present(input logic [31:0] a, input logic [31:0] d, input lsu_op_e op);
        sb_req_valid = 1'b1;
        sb_req_addr  = a;
        sb_req_data  = d;
        sb_req_op    = op;
        tick();
        sb_req_valid = 1'b0;
    endtask

    task automatic respond(input logic err);
        mem_rsp_valid = 1'b1;
        mem_rsp_err   = err;
        tick();
        mem_rsp_valid = 1'b0;
        mem_rsp_err   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        sb_req_valid  = 1'b0;
        sb_req_addr   = '0;
        sb_req_data   = '0;
        sb_req_op     = LSU_SB;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_err   = 1'b0;

        // Reset state
        #2;
        check("rst_idle",    idle, 1);
        check("rst_sb_rdy",  sb_req_ready, 1);
        check("rst_mem_vld", mem_req_valid, 0);
        check("rst_err",     store_err, 0);
        check("rst_wstrb",   mem_req_wstrb, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Aligned SW, ready tied high, response one cycle after the handshake
        mem_req_ready = 1'b1;
        check("sw_rdy_N", sb_req_ready, 1);
        present(32'h8000_0004, 32'hDEAD_BEEF, LSU_SW);
        check("sw_vld_N1",  mem_req_valid, 1);
        check("sw_addr",    mem_req_addr, 32'h8000_0004);
        check("sw_wstrb",   mem_req_wstrb, 4'hF);
        check("sw_wdata",   mem_req_wdata, 32'hDEAD_BEEF);
        check("sw_sb_busy", sb_req_ready, 0);
        tick();
        check("sw_wait_novld", mem_req_valid, 0);
        check("sw_wait_busy",  idle, 0);
        respond(1'b0);
        check("sw_accept_N3", sb_req_ready, 1);
        check("sw_no_err",    store_err, 0);

        // SB to the top byte lane
        present(32'h0000_1003, 32'h0000_00AB, LSU_SB);
        check("sb_addr",  mem_req_addr, 32'h0000_1000);
        check("sb_wstrb", mem_req_wstrb, 4'b1000);
        check("sb_wdata", mem_req_wdata, 32'hAB00_0000);
        tick();
        respond(1'b0);

        // Aligned SH in the upper half
        present(32'h0000_1002, 32'h0000_5678, LSU_SH);
        check("sh_addr",  mem_req_addr, 32'h0000_1000);
        check("sh_wstrb", mem_req_wstrb, 4'b1100);
        check("sh_wdata", mem_req_wdata, 32'h5678_0000);
        tick();
        respond(1'b0);

        // Backpressure for 5 cycles, handshake on the 6th; a response in the
        // handshake cycle must be ignored.
        mem_req_ready = 1'b0;
        present(32'h0000_4008, 32'h1122_3344, LSU_SW);
        for (int i = 0; i < 5; i++) begin
            check("bp_vld",   mem_req_valid, 1);
            check("bp_addr",  mem_req_addr, 32'h0000_4008);
            check("bp_wdata", mem_req_wdata, 32'h1122_3344);
            check("bp_wstrb", mem_req_wstrb, 4'hF);
            check("bp_sb_rdy", sb_req_ready, 0);
            tick();
        end
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b1;
        check("bp_vld_6th", mem_req_valid, 1);
        tick();
        mem_rsp_valid = 1'b0;
        check("bp_hs_done",        mem_req_valid, 0);
        check("same_cycle_rsp_ign", idle, 0);
        respond(1'b0);
        check("bp_back_idle", idle, 1);

        // Bus error
        present(32'h0000_2000, 32'hCAFE_F00D, LSU_SW);
        tick();
        respond(1'b1);
        check("bus_err",       store_err, 1);
        check("bus_cause",     store_err_cause, 0);
        check("bus_addr",      store_err_addr, 32'h0000_2000);
        check("bus_idle",      idle, 1);
        tick();
        check("bus_err_1cyc",  store_err, 0);
        check("bus_next_rdy",  sb_req_ready, 1);
        present(32'h0000_2004, 32'h0BAD_F00D, LSU_SW);
        check("bus_next_vld",  mem_req_valid, 1);
        check("bus_next_addr", mem_req_addr, 32'h0000_2004);
        tick();
        respond(1'b0);

        // Timeout after 8 WAIT cycles, then a stray response
        present(32'h0000_5000, 32'h0000_0001, LSU_SW);
        tick();
        for (int i = 0; i < 7; i++) begin
            check("to_waiting", idle, 0);
            tick();
        end
        check("to_wait_8th", idle, 0);
        tick();
        check("to_err",   store_err, 1);
        check("to_cause", store_err_cause, 1);
        check("to_addr",  store_err_addr, 32'h0000_5000);
        check("to_idle",  idle, 1);
        respond(1'b1);
        check("to_stray_ign", store_err, 0);
        check("to_stray_idle", idle, 1);
        check("to_stray_novld", mem_req_valid, 0);

        // Misaligned SH
        present(32'h0000_3001, 32'h0000_1234, LSU_SH);
`ifdef DCACHE_STORE_PORT_MISALIGN_CHECK_EN
        check("mis_novld", mem_req_valid, 0);
        check("mis_err",   store_err, 1);
        check("mis_cause", store_err_cause, 2);
        check("mis_addr",  store_err_addr, 32'h0000_3001);
        tick();
        check("mis_err_1cyc", store_err, 0);
`else
        check("mis_vld",   mem_req_valid, 1);
        check("mis_wstrb", mem_req_wstrb, 4'b0011);
        check("mis_addr",  mem_req_addr, 32'h0000_3000);
        check("mis_wdata", mem_req_wdata, 32'h0000_1234);
        check("mis_noerr", store_err, 0);
        tick();
        respond(1'b0);
`endif

        // SD is illegal on a 32-bit datapath
        present(32'h0000_6000, 32'h0000_0000, LSU_SD);
        check("ill_novld", mem_req_valid, 0);
        check("ill_err",   store_err, 1);
        check("ill_cause", store_err_cause, 3);
        check("ill_addr",  store_err_addr, 32'h0000_6000);
        tick();
        check("ill_err_1cyc", store_err, 0);
        check("ill_idle",     idle, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
